// File: rtl/egress_reader_if.sv
// Egress reader port bundle: FIFO side (empty flags, read data, pops)
// and downstream side (registered word, handshake, status, counters).
interface egress_reader_if #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_SIZE  = 5
);
    logic                 fifo_empty_e0;
    logic                 fifo_empty_e1;
    logic [DATA_SIZE-1:0] data_in_e0;
    logic [DATA_SIZE-1:0] data_in_e1;
    logic                 pop_e0;
    logic                 pop_e1;
    logic [DATA_SIZE-1:0] data_out;
    logic                 dest_out;
    logic                 valid_out;
    logic                 ready_out;
    logic                 idle;
    logic [CNT_SIZE-1:0]  count_e0;
    logic [CNT_SIZE-1:0]  count_e1;

    modport slave (
        input  fifo_empty_e0,
        input  fifo_empty_e1,
        input  data_in_e0,
        input  data_in_e1,
        input  ready_out,
        output pop_e0,
        output pop_e1,
        output data_out,
        output dest_out,
        output valid_out,
        output idle,
        output count_e0,
        output count_e1
    );

    modport master (
        output fifo_empty_e0,
        output fifo_empty_e1,
        output data_in_e0,
        output data_in_e1,
        output ready_out,
        input  pop_e0,
        input  pop_e1,
        input  data_out,
        input  dest_out,
        input  valid_out,
        input  idle,
        input  count_e0,
        input  count_e1
    );
endinterface

// File: rtl/egress_reader.sv
// Round-robin reader of two egress FIFOs into one registered stream with skid.
// Define EGRESS_READER_WORD_COUNT_EN to enable per-port accepted-word counters.
module egress_reader #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_SIZE  = 5
) (
    input  logic           clk,
    input  logic           reset,
    egress_reader_if.slave io
);
    logic                 pend_valid;
    logic                 pend_port;
    logic                 skid_valid;
    logic                 skid_dest;
    logic [DATA_SIZE-1:0] skid_data;
    logic                 out_valid;
    logic                 out_dest;
    logic [DATA_SIZE-1:0] out_data;
    logic                 last_grant;

    logic                 pop_ok;
    logic                 pop0;
    logic                 pop1;
    logic                 load;
    logic [DATA_SIZE-1:0] pend_data;

    // A held output register or an occupied skid blocks new pops, so at
    // most one word can ever be in flight beyond the output register.
    always_comb begin
        pop_ok    = !reset && !skid_valid && !(out_valid && !io.ready_out);
        pop0      = pop_ok && !io.fifo_empty_e0
                    && (io.fifo_empty_e1 || last_grant);
        pop1      = pop_ok && !io.fifo_empty_e1
                    && (io.fifo_empty_e0 || !last_grant);
        load      = !out_valid || io.ready_out;
        pend_data = pend_port ? io.data_in_e1 : io.data_in_e0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_port  <= 1'b0;
            skid_valid <= 1'b0;
            skid_dest  <= 1'b0;
            skid_data  <= '0;
            out_valid  <= 1'b0;
            out_dest   <= 1'b0;
            out_data   <= '0;
            last_grant <= 1'b1;
        end else begin
            pend_valid <= pop0 || pop1;
            pend_port  <= pop1;
            if (pop0 || pop1) begin
                last_grant <= pop1;
            end
            if (load) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_dest   <= skid_dest;
                    out_data   <= skid_data;
                    skid_valid <= pend_valid;
                    skid_dest  <= pend_port;
                    skid_data  <= pend_data;
                end else if (pend_valid) begin
                    out_valid <= 1'b1;
                    out_dest  <= pend_port;
                    out_data  <= pend_data;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (pend_valid) begin
                skid_valid <= 1'b1;
                skid_dest  <= pend_port;
                skid_data  <= pend_data;
            end
        end
    end

    assign io.pop_e0    = pop0;
    assign io.pop_e1    = pop1;
    assign io.data_out  = out_data;
    assign io.dest_out  = out_dest;
    assign io.valid_out = out_valid;
    assign io.idle      = !pend_valid && !skid_valid && !out_valid
                          && io.fifo_empty_e0 && io.fifo_empty_e1;

`ifdef EGRESS_READER_WORD_COUNT_EN
    logic [CNT_SIZE-1:0] cnt0;
    logic [CNT_SIZE-1:0] cnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (out_valid && io.ready_out) begin
            if (out_dest) begin
                cnt1 <= cnt1 + 1'b1;
            end else begin
                cnt0 <= cnt0 + 1'b1;
            end
        end
    end

    assign io.count_e0 = cnt0;
    assign io.count_e1 = cnt1;
`else
    assign io.count_e0 = {CNT_SIZE{1'b0}};
    assign io.count_e1 = {CNT_SIZE{1'b0}};
`endif
endmodule

// File: tb/tb_egress_reader.sv
// Bench for egress_reader: FIFO models, scoreboard, vector table and
// hand sequences for hold/skid, reset-with-skid, counter wrap, random ready.
module tb_egress_reader;
    localparam int DW = 8;
    localparam int CW = 5;

    typedef struct {
        logic [7:0] e0[4];
        int         n0;
        logic [7:0] e1[4];
        int         n1;
        logic [8:0] exp[8];
        int         nexp;
    } vec_t;

    typedef struct {
        logic       dest;
        logic [7:0] data;
        int         cyc;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    egress_reader_if #(.DATA_SIZE(DW), .CNT_SIZE(CW)) bus ();

    egress_reader #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    sb_t  exp_q[$];
    logic [8:0] got_q[$];
    logic pop0_s = 1'b0;
    logic pop1_s = 1'b0;
    bit   chk_lat = 1'b0;
    int   mcnt0 = 0;
    int   mcnt1 = 0;
    vec_t vecs[4];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO models: act on pops sampled at the previous negedge
    always @(posedge clk) begin
        logic [7:0] w;
        cyc++;
        if (!reset) begin
            if (pop0_s) begin
                check("pop_nonempty_e0", q0.size() != 0, 1);
                if (q0.size() != 0) begin
                    w = q0.pop_front();
                    bus.data_in_e0 <= w;
                    exp_q.push_back('{1'b0, w, cyc});
                end
            end
            if (pop1_s) begin
                check("pop_nonempty_e1", q1.size() != 0, 1);
                if (q1.size() != 0) begin
                    w = q1.pop_front();
                    bus.data_in_e1 <= w;
                    exp_q.push_back('{1'b1, w, cyc});
                end
            end
        end
        bus.fifo_empty_e0 <= (q0.size() == 0);
        bus.fifo_empty_e1 <= (q1.size() == 0);
    end

    // Output side: scoreboard compare, acceptance, model counters
    always @(negedge clk) begin
        pop0_s = bus.pop_e0;
        pop1_s = bus.pop_e1;
        if (pop0_s && pop1_s) begin
            check("single_pop", {31'd0, pop0_s & pop1_s}, 0);
        end
        if (bus.valid_out === 1'b1) begin
            check("sb_have", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check("sb_data", bus.data_out, exp_q[0].data);
                check("sb_dest", bus.dest_out, exp_q[0].dest);
                if (chk_lat) begin
                    check("latency", cyc - exp_q[0].cyc, 1);
                end
                if (bus.ready_out) begin
                    got_q.push_back({exp_q[0].dest, exp_q[0].data});
                    if (exp_q[0].dest) mcnt1++;
                    else mcnt0++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        got_q.delete();
        mcnt0 = 0;
        mcnt1 = 0;
        #1;
        check("rst_valid", bus.valid_out, 0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            done = (q0.size() == 0) && (q1.size() == 0)
                   && (exp_q.size() == 0) && (bus.idle === 1'b1);
        end
        check("drain_timeout", done, 1);
    endtask

    task automatic wait_valid(input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            done = (bus.valid_out === 1'b1);
        end
        check("valid_timeout", done, 1);
    endtask

    task automatic check_counts;
`ifdef EGRESS_READER_WORD_COUNT_EN
        check("count_e0", bus.count_e0, mcnt0 % 32);
        check("count_e1", bus.count_e1, mcnt1 % 32);
`else
        check("count_e0", bus.count_e0, 0);
        check("count_e1", bus.count_e1, 0);
`endif
    endtask

    initial begin
        logic [7:0] nxt;
        int left;
        reset = 1'b1;
        bus.ready_out = 1'b1;
        vecs[0] = '{'{8'hFF, 8'hBB, 8'h00, 8'h00}, 2,
                    '{8'h00, 8'h00, 8'h00, 8'h00}, 0,
                    '{9'h0FF, 9'h0BB, 0, 0, 0, 0, 0, 0}, 2};
        vecs[1] = '{'{8'hAB, 8'hAC, 8'h00, 8'h00}, 2,
                    '{8'hFA, 8'hCC, 8'h00, 8'h00}, 2,
                    '{9'h0AB, 9'h1FA, 9'h0AC, 9'h1CC, 0, 0, 0, 0}, 4};
        vecs[2] = '{'{8'h00, 8'h00, 8'h00, 8'h00}, 0,
                    '{8'h11, 8'h22, 8'h33, 8'h00}, 3,
                    '{9'h111, 9'h122, 9'h133, 0, 0, 0, 0, 0}, 3};
        vecs[3] = '{'{8'h01, 8'h02, 8'h03, 8'h00}, 3,
                    '{8'hA1, 8'h00, 8'h00, 8'h00}, 1,
                    '{9'h001, 9'h1A1, 9'h002, 9'h003, 0, 0, 0, 0}, 4};

        // reset state, both FIFOs empty
        repeat (3) @(negedge clk);
        check("rst_pop_e0", bus.pop_e0, 0);
        check("rst_pop_e1", bus.pop_e1, 0);
        check("rst_idle", bus.idle, 1);
        check_counts();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_pop", {bus.pop_e0, bus.pop_e1}, 0);
        check("post_valid", bus.valid_out, 0);
        check("post_idle", bus.idle, 1);

        // table-driven vectors, ready held high
        for (int i = 0; i < 4; i++) begin
            do_reset(2);
            chk_lat = 1'b1;
            for (int j = 0; j < vecs[i].n0; j++) q0.push_back(vecs[i].e0[j]);
            for (int j = 0; j < vecs[i].n1; j++) q1.push_back(vecs[i].e1[j]);
            wait_drain(100);
            check("vec_len", got_q.size(), vecs[i].nexp);
            for (int j = 0; j < vecs[i].nexp && j < got_q.size(); j++) begin
                check($sformatf("vec%0d_word%0d", i, j), got_q[j], vecs[i].exp[j]);
            end
            check_counts();
            chk_lat = 1'b0;
        end

        // ready low for 3 cycles mid-stream from E1
        do_reset(2);
        for (int j = 0; j < 8; j++) q1.push_back(8'h10 + 8'(j));
        wait_valid(20);
        @(posedge clk);
        #1;
        bus.ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_nopop", {bus.pop_e0, bus.pop_e1}, 0);
            check("hold_valid", bus.valid_out, 1);
        end
        @(posedge clk);
        #1;
        bus.ready_out = 1'b1;
        wait_drain(100);
        check("hold_len", got_q.size(), 8);
        for (int j = 0; j < 8 && j < got_q.size(); j++) begin
            check($sformatf("hold_word%0d", j), got_q[j], {1'b1, 8'h10 + 8'(j)});
        end
        check_counts();

        // reset while a word sits in skid
        do_reset(2);
        for (int j = 0; j < 8; j++) q1.push_back(8'h20 + 8'(j));
        wait_valid(20);
        @(posedge clk);
        #1;
        bus.ready_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        got_q.delete();
        mcnt0 = 0;
        mcnt1 = 0;
        #1;
        check("skid_rst_valid", bus.valid_out, 0);
        check("skid_rst_pop", {bus.pop_e0, bus.pop_e1}, 0);
        nxt = q1[0];
        left = q1.size();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.ready_out = 1'b1;
        wait_drain(100);
        check("skid_rst_len", got_q.size(), left);
        if (got_q.size() != 0) begin
            check("skid_rst_next", got_q[0], {1'b1, nxt});
        end

        // 33 E0 words: counter wraps
        do_reset(2);
        for (int j = 0; j < 33; j++) q0.push_back(8'(j * 3));
        wait_drain(200);
`ifdef EGRESS_READER_WORD_COUNT_EN
        check("wrap_e0", bus.count_e0, 1);
`else
        check("wrap_e0", bus.count_e0, 0);
`endif
        check("wrap_e1", bus.count_e1, 0);
        check("wrap_seen", mcnt0, 33);

        // mixed traffic with random backpressure
        do_reset(2);
        for (int j = 0; j < 20; j++) begin
            q0.push_back(8'($urandom));
            q1.push_back(8'($urandom));
        end
        for (int k = 0; k < 400 && (exp_q.size() != 0 || q0.size() != 0
             || q1.size() != 0); k++) begin
            @(posedge clk);
            #1;
            bus.ready_out = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk);
        #1;
        bus.ready_out = 1'b1;
        wait_drain(100);
        check("rand_len", got_q.size(), 40);
        check_counts();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
